// File: rtl/triangle_raster_scheduler_pkg.sv
// Shared types for the triangle raster scheduler: FSM states, vertex layout, degenerate-area helper.
// The area helper exists only when SCHED_DEGEN_CULL_EN is defined.
package triangle_raster_scheduler_pkg;

   localparam int VTX_W = 8;
   localparam int TRI_W = 6 * VTX_W;

   // Field order puts ax at the MSB of each 48-bit requester slot.
   typedef struct packed {
      logic [VTX_W-1:0] ax;
      logic [VTX_W-1:0] ay;
      logic [VTX_W-1:0] bx;
      logic [VTX_W-1:0] by;
      logic [VTX_W-1:0] cx;
      logic [VTX_W-1:0] cy;
   } tri_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_BUSY,
      ST_DONE
   } state_t;

`ifdef SCHED_DEGEN_CULL_EN
   // Twice the signed triangle area; zero means the three vertices are collinear.
   function automatic logic signed [17:0] area2(input tri_t t);
      logic signed [8:0] e1x, e1y, e2x, e2y;
      e1x = $signed({1'b0, t.bx}) - $signed({1'b0, t.ax});
      e1y = $signed({1'b0, t.by}) - $signed({1'b0, t.ay});
      e2x = $signed({1'b0, t.cx}) - $signed({1'b0, t.ax});
      e2y = $signed({1'b0, t.cy}) - $signed({1'b0, t.ay});
      return e1x * e2y - e1y * e2x;
   endfunction
`endif

endpackage

// File: rtl/triangle_raster_scheduler_if.sv
// Requester and rasteriser-side signal bundle for the triangle raster scheduler.
interface triangle_raster_scheduler_if
   import triangle_raster_scheduler_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int CW   = 3
);

   logic [NREQ-1:0]       req;
   logic [NREQ*TRI_W-1:0] tri_vtx;
   logic [NREQ*CW-1:0]    tri_colour;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [VTX_W-1:0]      dt_ax, dt_ay, dt_bx, dt_by, dt_cx, dt_cy;
   logic [CW-1:0]         dt_colour;
   logic                  dt_draw_en;
   logic                  dt_done;

   modport slave (
      input  req, tri_vtx, tri_colour, dt_done,
      output gnt, done, busy, dt_ax, dt_ay, dt_bx, dt_by, dt_cx, dt_cy, dt_colour, dt_draw_en
   );

   modport master (
      output req, tri_vtx, tri_colour, dt_done,
      input  gnt, done, busy, dt_ax, dt_ay, dt_bx, dt_by, dt_cx, dt_cy, dt_colour, dt_draw_en
   );

endinterface

// File: rtl/triangle_raster_scheduler_rr_arbiter.sv
// Combinational round-robin select: first set request at or after the pointer, wrapping.
module triangle_raster_scheduler_rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic found;
   int   cand;

   // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
   always_comb begin
      found = 1'b0;
      cand  = 0;
      idx_o = '0;
      gnt_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && req_i[IDX_W'(cand)]) begin
            found                = 1'b1;
            idx_o                = IDX_W'(cand);
            gnt_o[IDX_W'(cand)]  = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/triangle_raster_scheduler.sv
// Shares one draw_triangle rasteriser between NREQ requesters with round-robin arbitration.
// Optional SCHED_DEGEN_CULL_EN: zero-area triangles are completed without being issued.
module triangle_raster_scheduler
   import triangle_raster_scheduler_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int CW   = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   triangle_raster_scheduler_if.slave   sched
);

   localparam int IDX_W = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] win_q, win_d, ptr_q, ptr_d;
   logic [NREQ-1:0]  win_oh_q, win_oh_d;
   tri_t             tri_q, tri_d;
   logic [CW-1:0]    colour_q, colour_d;

   logic [NREQ-1:0]  arb_oh;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_valid;
   logic [NREQ-1:0]  gnt_c, done_c;
   logic             draw_en_c;

   tri_t             slot_tri [NREQ];
   logic [CW-1:0]    slot_col [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      assign slot_tri[i] = tri_t'(sched.tri_vtx[TRI_W*i +: TRI_W]);
      assign slot_col[i] = sched.tri_colour[CW*i +: CW];
   end

   triangle_raster_scheduler_rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i   (sched.req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_oh),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         win_oh_q <= '0;
         ptr_q    <= '0;
         tri_q    <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         win_oh_q <= win_oh_d;
         ptr_q    <= ptr_d;
         tri_q    <= tri_d;
         colour_q <= colour_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      win_oh_d  = win_oh_q;
      ptr_d     = ptr_q;
      tri_d     = tri_q;
      colour_d  = colour_q;
      gnt_c     = '0;
      done_c    = '0;
      draw_en_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A busy rasteriser blocks the decision so no grant is issued that cannot start.
            if (arb_valid && sched.dt_done) begin
               win_d    = arb_idx;
               win_oh_d = arb_oh;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            gnt_c    = win_oh_q;
            tri_d    = slot_tri[win_q];
            colour_d = slot_col[win_q];
            ptr_d    = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef SCHED_DEGEN_CULL_EN
            state_d  = (area2(slot_tri[win_q]) == '0) ? ST_DONE : ST_START;
`else
            state_d  = ST_START;
`endif
         end
         ST_START: begin
            draw_en_c = 1'b1;
            if (!sched.dt_done) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (sched.dt_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_c  = win_oh_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sched.gnt        = gnt_c;
   assign sched.done       = done_c;
   assign sched.busy       = (state_q != ST_IDLE);
   assign sched.dt_draw_en = draw_en_c;
   assign sched.dt_ax      = tri_q.ax;
   assign sched.dt_ay      = tri_q.ay;
   assign sched.dt_bx      = tri_q.bx;
   assign sched.dt_by      = tri_q.by;
   assign sched.dt_cx      = tri_q.cx;
   assign sched.dt_cy      = tri_q.cy;
   assign sched.dt_colour  = colour_q;

endmodule
